irsx_register_write_sequencer: RTL and testbench

- Upstream feeder for the IRSX register interface. It owns that block's address, intended_data and write_enable inputs.
- Accepts host register writes through a 4-deep valid/ready FIFO and issues each as a single-cycle write strobe into the intended-values RAM.
- After each write, polls readback_data_out at the same address until it equals the written value, or until a timeout.
- Counts verified writes and timeouts for status readout.

---
 rtl/irsx_pkg.sv | 37 +++
 rtl/irsx_request_fifo.sv | 62 ++++++
 rtl/irsx_register_write_sequencer.sv | 170 +++++++++++++++++
 tb/tb_irsx_register_write_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irsx_pkg.sv
// irsx_pkg: shared widths, sequencer state encoding and the
// power-on default register table used by IRSX_DEFAULTS_LOAD_EN.
package irsx_pkg;

    localparam int IRSX_ADDR_W = 8;
    localparam int IRSX_DATA_W = 12;
    localparam int IRSX_REQ_W  = IRSX_ADDR_W + IRSX_DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_WAIT    = 3'd4,
        ST_LOAD    = 3'd5
    } irsx_state_e;

    typedef struct packed {
        logic [IRSX_ADDR_W-1:0] addr;
        logic [IRSX_DATA_W-1:0] data;
    } irsx_req_t;

    localparam int IRSX_NUM_DEFAULTS = 4;

    function automatic irsx_req_t irsx_default(input logic [31:0] idx);
        irsx_req_t r;
        case (idx)
            32'd0:   r = '{addr: 8'h00, data: 12'h0F0};
            32'd1:   r = '{addr: 8'h01, data: 12'h3A5};
            32'd2:   r = '{addr: 8'h10, data: 12'h800};
            32'd3:   r = '{addr: 8'h2C, data: 12'h155};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/irsx_request_fifo.sv
// irsx_request_fifo: synchronous request FIFO with occupancy count.
// A push while full is taken only together with a pop.
module irsx_request_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Entry storage, written at the tail pointer.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/irsx_register_write_sequencer.sv
// irsx_register_write_sequencer: queues host writes, strobes them into
// the IRSX RAM and polls readback. Option macro: IRSX_DEFAULTS_LOAD_EN.
module irsx_register_write_sequencer
    import irsx_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int BRAM_LATENCY  = 2,
    parameter int POLL_INTERVAL = 63,
    parameter int TIMEOUT_POLLS = 1023
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [IRSX_ADDR_W-1:0] req_address,
    input  logic [IRSX_DATA_W-1:0] req_data,
    output logic [IRSX_ADDR_W-1:0] address,
    output logic [IRSX_DATA_W-1:0] intended_data,
    output logic                   write_enable,
    input  logic [IRSX_DATA_W-1:0] readback_data_out,
    output logic                   busy,
    output logic [31:0]            verified_count,
    output logic [31:0]            timeout_count,
    output logic [IRSX_ADDR_W-1:0] last_timeout_address
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(BRAM_LATENCY + 1) + 1;
    localparam int WW = $clog2(POLL_INTERVAL + 1) + 1;
    localparam int PW = $clog2(TIMEOUT_POLLS + 1) + 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(BRAM_LATENCY);
    localparam logic [WW-1:0] WAIT_LAST   = WW'(POLL_INTERVAL - 1);
    localparam logic [PW-1:0] POLL_LAST   = PW'(TIMEOUT_POLLS);

    irsx_state_e       r_state;
    logic [SW-1:0]     r_settle_cnt;
    logic [WW-1:0]     r_wait_cnt;
    logic [PW-1:0]     r_poll_cnt;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_load;
    logic [IRSX_REQ_W-1:0] w_fifo_q;
    irsx_req_t         w_head;

`ifdef IRSX_DEFAULTS_LOAD_EN
    localparam int LW = $clog2(IRSX_NUM_DEFAULTS) + 1;
    localparam logic [LW-1:0] LOAD_LAST = LW'(IRSX_NUM_DEFAULTS - 1);
    localparam irsx_state_e RESET_STATE = ST_LOAD;
    logic [LW-1:0] r_load_idx;
    logic          r_load_phase;
    irsx_req_t     w_def;
    assign w_def  = irsx_default(32'(r_load_idx));
    assign w_load = (r_state == ST_LOAD);
`else
    localparam irsx_state_e RESET_STATE = ST_IDLE;
    assign w_load = 1'b0;
`endif

    assign req_ready = !reset && !w_full && !w_load;
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign w_head    = irsx_req_t'(w_fifo_q);
    assign busy      = (w_count != '0) || (r_state != ST_IDLE);

    irsx_request_fifo #(
        .WIDTH (IRSX_REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({req_address, req_data}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Write/settle/compare/wait sequencer with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state              <= RESET_STATE;
            r_settle_cnt         <= '0;
            r_wait_cnt           <= '0;
            r_poll_cnt           <= '0;
            address              <= '0;
            intended_data        <= '0;
            write_enable         <= 1'b0;
            verified_count       <= '0;
            timeout_count        <= '0;
            last_timeout_address <= '0;
`ifdef IRSX_DEFAULTS_LOAD_EN
            r_load_idx           <= '0;
            r_load_phase         <= 1'b0;
`endif
        end else begin
            write_enable <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        address       <= w_head.addr;
                        intended_data <= w_head.data;
                        write_enable  <= 1'b1;
                        r_state       <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_poll_cnt   <= '0;
                    r_wait_cnt   <= '0;
                    r_settle_cnt <= '0;
                    r_state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= ST_COMPARE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    if (readback_data_out == intended_data) begin
                        verified_count <= verified_count + 32'd1;
                        r_state        <= ST_IDLE;
                    end else if (r_poll_cnt == POLL_LAST) begin
                        timeout_count        <= timeout_count + 32'd1;
                        last_timeout_address <= address;
                        r_state              <= ST_IDLE;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_settle_cnt <= '0;
                        r_state      <= ST_SETTLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
`ifdef IRSX_DEFAULTS_LOAD_EN
                ST_LOAD: begin
                    if (!r_load_phase) begin
                        address       <= w_def.addr;
                        intended_data <= w_def.data;
                        write_enable  <= 1'b1;
                        r_load_phase  <= 1'b1;
                    end else begin
                        r_load_phase <= 1'b0;
                        if (r_load_idx == LOAD_LAST) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_load_idx <= r_load_idx + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irsx_register_write_sequencer.sv
// tb_irsx_register_write_sequencer: random and directed host writes
// against a delayed-mirror / stuck readback RAM, scoreboarded strobes.
module tb_irsx_register_write_sequencer;

    localparam int DEPTH     = 4;
    localparam int LAT       = 2;
    localparam int PI        = 5;
    localparam int TP        = 3;
    localparam int FIRST_CMP = 1 + 1 + 1 + (LAT + 1) + 1;
    localparam int RETRY     = PI + (LAT + 1) + 1;
    localparam int TO_LAT    = FIRST_CMP + TP * RETRY;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_address = '0;
    logic [11:0] req_data = '0;
    logic [7:0]  address;
    logic [11:0] intended_data;
    logic        write_enable;
    logic [11:0] readback_data_out;
    logic        busy;
    logic [31:0] verified_count;
    logic [31:0] timeout_count;
    logic [7:0]  last_timeout_address;

    typedef struct packed { logic [7:0] a; logic [11:0] d; } sb_t;
    typedef struct { int due; logic [7:0] a; logic [11:0] d; } upd_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc = 0;
    int pops = 0;
    int exp_ver = 0;
    int exp_to = 0;
    logic [7:0] exp_last = '0;
    sb_t exp_strobe[$];
    upd_t pend[$];
    logic [11:0] mem [256];
    logic [11:0] rb1 = '0;
    logic [11:0] rb2 = '0;
    bit stuck = 1'b0;
    int model_delay = 0;
    bit prev_we = 1'b0;
    bit saw_low = 1'b0;

    always #5 clock = ~clock;

    irsx_register_write_sequencer #(
        .FIFO_DEPTH    (DEPTH),
        .BRAM_LATENCY  (LAT),
        .POLL_INTERVAL (PI),
        .TIMEOUT_POLLS (TP)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_address          (req_address),
        .req_data             (req_data),
        .address              (address),
        .intended_data        (intended_data),
        .write_enable         (write_enable),
        .readback_data_out    (readback_data_out),
        .busy                 (busy),
        .verified_count       (verified_count),
        .timeout_count        (timeout_count),
        .last_timeout_address (last_timeout_address)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register RAM: strobes land after model_delay, read is 2-cycle.
    always @(posedge clock) begin
        cyc++;
        if (write_enable)
            pend.push_back('{cyc + model_delay, address, intended_data});
        while (pend.size() > 0 && pend[0].due <= cyc) begin
            mem[pend[0].a] = pend[0].d;
            pend.delete(0);
        end
        rb1 <= mem[address];
        rb2 <= rb1;
    end

    assign readback_data_out = stuck ? 12'h000 : rb2;

    // Monitor: strobes against the scoreboard, ready against occupancy.
    always @(negedge clock) begin
        sb_t e;
        #1;
        if (write_enable) begin
            pops++;
            chk("we_one_cycle", 64'(prev_we), 64'd0);
            chk("strobe_pending", 64'(exp_strobe.size() != 0), 64'd1);
            if (exp_strobe.size() != 0) begin
                e = exp_strobe.pop_front();
                chk("strobe_addr", 64'(address), 64'(e.a));
                chk("strobe_data", 64'(intended_data), 64'(e.d));
            end
        end
        chk("req_ready", 64'(req_ready),
            64'(!reset && (acc - pops) < DEPTH));
        prev_we = write_enable;
    end

    task automatic push(input logic [7:0] a, input logic [11:0] d);
        bit ok = 1'b0;
        req_valid   = 1'b1;
        req_address = a;
        req_data    = d;
        for (int n = 0; n < 300 && !ok; n++) begin
            #1;
            if (req_ready) begin
                @(posedge clock);
                acc++;
                exp_strobe.push_back('{a, d});
                if (stuck) begin
                    exp_to++;
                    exp_last = a;
                end else begin
                    exp_ver++;
                end
                ok = 1'b1;
            end else begin
                saw_low = 1'b1;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        chk("push_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle_and_check(input string tag);
        int n = 0;
        @(negedge clock);
        #2;
        while ((busy || exp_strobe.size() != 0) && n < 3000) begin
            @(negedge clock);
            #2;
            n++;
        end
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_verified"}, 64'(verified_count), 64'(exp_ver));
        chk({tag, "_timeouts"}, 64'(timeout_count), 64'(exp_to));
        chk({tag, "_last_to"}, 64'(last_timeout_address), 64'(exp_last));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_address"}, 64'(address), 64'd0);
        chk({tag, "_data"}, 64'(intended_data), 64'd0);
        chk({tag, "_we"}, 64'(write_enable), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_verified"}, 64'(verified_count), 64'd0);
        chk({tag, "_timeouts"}, 64'(timeout_count), 64'd0);
        chk({tag, "_last_to"}, 64'(last_timeout_address), 64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;

        repeat (3) @(negedge clock);
        #2;
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clock);
        #2;
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        stuck = 1'b0;
        model_delay = 10;
        @(negedge clock);
        push(8'h98, 12'h765);
        wait_idle_and_check("mirror");

        model_delay = 0;
        @(negedge clock);
        push(8'h05, 12'hABC);
        wait_idle_and_check("preload");
        @(negedge clock);
        push(8'h05, 12'hABC);
        repeat (FIRST_CMP - 2) @(negedge clock);
        #2;
        chk("lat_before", 64'(verified_count), 64'(exp_ver - 1));
        @(negedge clock);
        #2;
        chk("lat_at", 64'(verified_count), 64'(exp_ver));
        wait_idle_and_check("same_value");

        stuck = 1'b1;
        @(negedge clock);
        push(8'h43, 12'h210);
        repeat (TO_LAT - 2) @(negedge clock);
        #2;
        chk("to_before", 64'(timeout_count), 64'(exp_to - 1));
        @(negedge clock);
        #2;
        chk("to_at", 64'(timeout_count), 64'(exp_to));
        wait_idle_and_check("timeout");

        stuck = 1'b0;
        model_delay = 20;
        saw_low = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 6; i++)
            push(8'(8'h0a + 9 * i), 12'($urandom_range(1, 4095)));
        chk("backpressure", 64'(saw_low), 64'd1);
        wait_idle_and_check("burst");

        stuck = 1'b1;
        @(negedge clock);
        push(8'h20, 12'h001);
        push(8'h21, 12'h002);
        push(8'h22, 12'h003);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        exp_strobe.delete();
        acc = 0;
        pops = 0;
        exp_ver = 0;
        exp_to = 0;
        exp_last = '0;
        reset = 1'b0;
        #2;
        chk_reset_vals("midrst");
        chk("midrst_ready", 64'(req_ready), 64'd1);
        repeat (60) @(negedge clock);
        #2;
        chk_reset_vals("postrst");

        for (int it = 0; it < 15; it++) begin
            int nreq;
            stuck = ($urandom_range(0, 3) == 0);
            model_delay = $urandom_range(0, 12);
            nreq = $urandom_range(1, 3);
            @(negedge clock);
            for (int k = 0; k < nreq; k++)
                push(8'($urandom), 12'($urandom_range(1, 4095)));
            wait_idle_and_check("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
